// File: rtl/karatsuba_dot_acc.sv
// Purpose: LEN-term dot product of WIDTH-bit unsigned pairs, one Karatsuba multiply per pair, ACC_W-bit wrapping sum.
// Latency: out_valid rises after the edge following acceptance of the LEN-th pair; one vector per LEN+2 cycles minimum.
// Backpressure: in_ready drops once LEN pairs are taken and stays low until the result handshakes; the result holds under out_ready=0.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand-pair handshake, operands on X/Y
//   out_valid/out_ready   result handshake, result on out_sum (mod 2^ACC_W) and out_ovf (sticky carry-out)

// Combinational 16x16 unsigned multiplier, single-level Karatsuba split into 8-bit halves.
module karatsuba_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] z
);
    logic [7:0]  a_hi, a_lo, b_hi, b_lo;
    logic [8:0]  a_sum, b_sum;
    logic [15:0] z_hi, z_lo;
    logic [17:0] z_cross;
    logic [17:0] z_mid;

    assign a_hi = a[15:8];
    assign a_lo = a[7:0];
    assign b_hi = b[15:8];
    assign b_lo = b[7:0];

    assign a_sum   = 9'(a_hi) + 9'(a_lo);
    assign b_sum   = 9'(b_hi) + 9'(b_lo);
    assign z_hi    = 16'(a_hi) * 16'(b_hi);
    assign z_lo    = 16'(a_lo) * 16'(b_lo);
    assign z_cross = 18'(a_sum) * 18'(b_sum);

    // Middle term a_hi*b_lo + a_lo*b_hi; never negative and fits in 17 bits.
    assign z_mid = z_cross - 18'(z_hi) - 18'(z_lo);

    // {z_hi, z_lo} places the outer partial products without an extra adder.
    assign z = {z_hi, z_lo} + (32'(z_mid) << 8);
endmodule

module karatsuba_dot_acc #(
    parameter int WIDTH = 16,
    parameter int LEN   = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] p_reg;
    logic               p_valid;
    logic               p_last;
    logic [ACC_W-1:0]   acc;
    logic               ovf;

    logic [2*WIDTH-1:0] z;
    logic               accept;
    logic [ACC_W:0]     acc_sum;

    karatsuba_16 u_mul (
        .a (X),
        .b (Y),
        .z (z)
    );

    assign in_ready = (state == ACCUM) && (count < LEN_C);
    assign accept   = in_valid && in_ready;

    // Extra top bit captures the carry out of the accumulator for the sticky flag.
    assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(p_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            count     <= '0;
            p_reg     <= '0;
            p_valid   <= 1'b0;
            p_last    <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            // Stage 1: product register.
            p_valid <= accept;
            if (accept) begin
                p_reg  <= z;
                p_last <= (count == LAST_C);
                count  <= count + CNT_W'(1);
            end

            // Stage 2: accumulate whatever product stage 1 holds.
            if (p_valid) begin
                acc <= acc_sum[ACC_W-1:0];
                ovf <= ovf | acc_sum[ACC_W];
            end

            case (state)
                ACCUM: begin
                    if (accept && (count == LAST_C)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Publish the sum including the last product, bypassing acc.
                    if (p_valid && p_last) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_sum   <= acc_sum[ACC_W-1:0];
                        out_ovf   <= ovf | acc_sum[ACC_W];
                    end
                end
                OUT: begin
                    // No product is in flight here, so clearing acc cannot collide with stage 2.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        count     <= '0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_dot_acc.sv
// Bench for karatsuba_dot_acc: three builds (LEN=8, LEN=3, LEN=1), directed and random vectors
// compared against a plain-arithmetic dot-product model.
module tb_karatsuba_dot_acc;
    logic             clk;
    logic             rst_n;
    logic [2:0]       in_valid;
    logic [2:0]       in_ready;
    logic [2:0][15:0] X;
    logic [2:0][15:0] Y;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [2:0][31:0] out_sum;
    logic [2:0]       out_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] vx[8];
    logic [15:0] vy[8];
    int lens[3] = '{8, 3, 1};

    karatsuba_dot_acc #(.WIDTH(16), .LEN(8), .ACC_W(32)) u_len8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .X(X[0]), .Y(Y[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_ovf(out_ovf[0])
    );
    karatsuba_dot_acc #(.WIDTH(16), .LEN(3), .ACC_W(32)) u_len3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .X(X[1]), .Y(Y[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_ovf(out_ovf[1])
    );
    karatsuba_dot_acc #(.WIDTH(16), .LEN(1), .ACC_W(32)) u_len1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .X(X[2]), .Y(Y[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(out_sum[2]), .out_ovf(out_ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: true dot product in 64 bits; result is its low 32 bits, flag is any carry past bit 31.
    task automatic model(input int n, output logic [31:0] s, output logic o);
        longint unsigned t;
        t = 0;
        for (int i = 0; i < n; i++) t += 64'(vx[i]) * 64'(vy[i]);
        s = t[31:0];
        o = (t >> 32) != 0;
    endtask

    task automatic run_vec(input int d, input int n, input bit bub, input int bp, input string nm);
        logic [31:0] es;
        logic        eo;
        int          i;
        int          guard;
        model(n, es, eo);
        out_ready[d] = (bp == 0);
        i = 0;
        guard = 0;
        while (i < n && guard < 200) begin
            if (bub && i > 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    in_valid[d] = 1'b0;
                    X[d] = 16'($urandom);
                    Y[d] = 16'($urandom);
                    check({nm, ".bubble_rdy"}, 64'(in_ready[d]), 64'(1));
                end
            end
            @(negedge clk);
            guard++;
            in_valid[d] = 1'b1;
            X[d] = vx[i];
            Y[d] = vy[i];
            check({nm, ".in_rdy"}, 64'(in_ready[d]), 64'(1));
            if (in_ready[d]) i++;
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
        check({nm, ".early_vld"}, 64'(out_valid[d]), 64'(0));
        check({nm, ".drain_rdy"}, 64'(in_ready[d]), 64'(0));
        @(negedge clk);
        check({nm, ".vld"}, 64'(out_valid[d]), 64'(1));
        check({nm, ".sum"}, 64'(out_sum[d]), 64'(es));
        check({nm, ".ovf"}, 64'(out_ovf[d]), 64'(eo));
        repeat (bp) begin
            @(negedge clk);
            X[d] = 16'($urandom);
            Y[d] = 16'($urandom);
            in_valid[d] = 1'($urandom);
            check({nm, ".hold_vld"}, 64'(out_valid[d]), 64'(1));
            check({nm, ".hold_sum"}, 64'(out_sum[d]), 64'(es));
            check({nm, ".hold_ovf"}, 64'(out_ovf[d]), 64'(eo));
            check({nm, ".hold_rdy"}, 64'(in_ready[d]), 64'(0));
        end
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        check({nm, ".post_vld"}, 64'(out_valid[d]), 64'(0));
        check({nm, ".post_rdy"}, 64'(in_ready[d]), 64'(1));
    endtask

    task automatic fill(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < 8; i++) begin
            vx[i] = a;
            vy[i] = b;
        end
    endtask

    initial begin
        int i;
        int guard;
        rst_n = 1'b0;
        in_valid = '0;
        X = '0;
        Y = '0;
        out_ready = '1;

        #2;
        for (int d = 0; d < 3; d++) begin
            check("rst.vld", 64'(out_valid[d]), 64'(0));
            check("rst.sum", 64'(out_sum[d]), 64'(0));
            check("rst.ovf", 64'(out_ovf[d]), 64'(0));
            check("rst.rdy", 64'(in_ready[d]), 64'(1));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // LEN=8 directed cases.
        for (int k = 0; k < 8; k++) begin
            vx[k] = 16'(k + 1);
            vy[k] = 16'(k + 1);
        end
        run_vec(0, 8, 1'b0, 0, "basic");
        fill(16'hFFFF, 16'hFFFF);
        run_vec(0, 8, 1'b0, 0, "ovf");
        fill(16'd2, 16'd3);
        run_vec(0, 8, 1'b0, 0, "ovf_clr");
        fill(16'h1234, 16'h00AB);
        run_vec(0, 8, 1'b0, 5, "backpressure");

        // Abort a vector part-way with an asynchronous reset pulse between edges.
        i = 0;
        guard = 0;
        while (i < 5 && guard < 50) begin
            @(negedge clk);
            guard++;
            in_valid[0] = 1'b1;
            X[0] = 16'd100;
            Y[0] = 16'd100;
            if (in_ready[0]) i++;
        end
        check("abort.accepted", 64'(i), 64'(5));
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("abort.vld", 64'(out_valid[0]), 64'(0));
        check("abort.sum", 64'(out_sum[0]), 64'(0));
        check("abort.ovf", 64'(out_ovf[0]), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("abort.post_vld", 64'(out_valid[0]), 64'(0));
        check("abort.post_rdy", 64'(in_ready[0]), 64'(1));
        fill(16'd1, 16'd7);
        run_vec(0, 8, 1'b0, 0, "after_abort");

        // LEN=3 with bubbles.
        vx[0] = 16'd10;  vy[0] = 16'd20;
        vx[1] = 16'd0;   vy[1] = 16'd5;
        vx[2] = 16'd300; vy[2] = 16'd300;
        run_vec(1, 3, 1'b1, 0, "bubbles");

        // LEN=1 zero and maximum operands.
        vx[0] = 16'hFFFF; vy[0] = 16'h0000;
        run_vec(2, 1, 1'b0, 0, "len1_zero");
        vx[0] = 16'hFFFF; vy[0] = 16'hFFFF;
        run_vec(2, 1, 1'b0, 0, "len1_max");

        // Random vectors on every build; odd rounds use large operands to provoke wrap-around.
        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < 8; k++) begin
                    if (r % 2 == 1) begin
                        vx[k] = 16'($urandom_range(16'hC000, 16'hFFFF));
                        vy[k] = 16'($urandom_range(16'hC000, 16'hFFFF));
                    end else begin
                        vx[k] = 16'($urandom);
                        vy[k] = 16'($urandom);
                    end
                end
                run_vec(d, lens[d], 1'($urandom), $urandom_range(0, 3), "random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
